wb_stage: RTL and testbench

Writeback stage of the five-stage LoongArch pipeline, directly downstream of the memory stage. Registers the memory-stage result bus and drives the GPR write port and the debug trace. Hosts the CSR file in its `csr_file` sub-module. Commits syscall exceptions and `ertn` by raising `wb_ex` / `ertn_flush` and supplying the redirect PC to fetch.

---
 rtl/csr_pkg.sv | 65 ++++++
 rtl/wb_stage_csr_file.sv | 187 ++++++++++++++++++
 rtl/wb_stage.sv | 103 ++++++++++
 tb/tb_wb_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// ============================================================================
// Module  : csr_pkg
// Brief   : CSR addresses, field positions, bus widths and the MEM->WB bundle
//           layout shared by the writeback stage and its CSR file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_pkg;

    localparam int MEM_WB_BUS_W = 185;
    localparam int WB_ID_BUS_W  = 53;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;

    localparam int CRMD_PLV_LSB     = 0;
    localparam int CRMD_PLV_MSB     = 1;
    localparam int CRMD_IE          = 2;
    localparam int CRMD_DA          = 3;
    localparam int PRMD_PPLV_LSB    = 0;
    localparam int PRMD_PPLV_MSB    = 1;
    localparam int PRMD_PIE         = 2;
    localparam int ESTAT_IS_LSB     = 0;
    localparam int ESTAT_IS_MSB     = 1;
    localparam int ESTAT_ECODE_LSB  = 16;
    localparam int ESTAT_ECODE_MSB  = 21;
    localparam int ESTAT_ESUB_LSB   = 22;
    localparam int ESTAT_ESUB_MSB   = 30;
    localparam int EENTRY_VA_LSB    = 6;

    localparam logic [5:0] ECODE_SYS = 6'h0B;

    typedef struct packed {
        logic        rsvd;
        logic        gr_we;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        csr_we;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        ertn;
        logic        syscall_ex;
    } mem_wb_bus_t;

    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] wmask,
                                              input logic [31:0] wvalue);
        return (old_val & ~wmask) | (wvalue & wmask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_stage_csr_file.sv
// ============================================================================
// Module  : csr_file
// Brief   : CSR registers with combinational read, masked write and the
//           exception / ertn commit updates.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_file
    import csr_pkg::*;
#(
    parameter int CSR_NUM_W = 14
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [CSR_NUM_W-1:0] i_csr_num,
    output logic [31:0]          o_csr_rdata,
    input  logic                 i_csr_we,
    input  logic [31:0]          i_csr_wmask,
    input  logic [31:0]          i_csr_wvalue,
    input  logic                 i_ex_commit,
    input  logic [31:0]          i_ex_pc,
    input  logic                 i_ertn_commit,
    output logic [31:0]          o_era,
    output logic [31:0]          o_eentry
);

    logic [1:0]  r_crmd_plv;
    logic        r_crmd_ie;
    logic        r_crmd_da;
    logic [1:0]  r_prmd_pplv;
    logic        r_prmd_pie;
    logic [1:0]  r_estat_is;
    logic [5:0]  r_estat_ecode;
    logic [8:0]  r_estat_esub;
    logic [31:0] r_era;
    logic [25:0] r_eentry_va;

    logic        w_sel_crmd;
    logic        w_sel_prmd;
    logic        w_sel_estat;
    logic        w_sel_era;
    logic        w_sel_eentry;
    logic [3:0]  w_sel_save;
    logic [31:0] w_save_rd [4];

    logic [31:0] w_crmd_rd;
    logic [31:0] w_prmd_rd;
    logic [31:0] w_estat_rd;
    logic [31:0] w_eentry_rd;

    logic [1:0]  w_plv_new;
    logic        w_ie_new;
    logic        w_da_new;
    logic [1:0]  w_pplv_new;
    logic        w_pie_new;
    logic [1:0]  w_is_new;
    logic [25:0] w_va_new;

    assign w_sel_crmd   = (i_csr_num == CSR_NUM_W'(CSR_CRMD));
    assign w_sel_prmd   = (i_csr_num == CSR_NUM_W'(CSR_PRMD));
    assign w_sel_estat  = (i_csr_num == CSR_NUM_W'(CSR_ESTAT));
    assign w_sel_era    = (i_csr_num == CSR_NUM_W'(CSR_ERA));
    assign w_sel_eentry = (i_csr_num == CSR_NUM_W'(CSR_EENTRY));

    assign w_crmd_rd   = {28'b0, r_crmd_da, r_crmd_ie, r_crmd_plv};
    assign w_prmd_rd   = {29'b0, r_prmd_pie, r_prmd_pplv};
    assign w_estat_rd  = {1'b0, r_estat_esub, r_estat_ecode, 14'b0, r_estat_is};
    assign w_eentry_rd = {r_eentry_va, 6'b0};

    // Only the architecturally writable bits of each CSR take part in the merge.
    assign w_plv_new  = (r_crmd_plv & ~i_csr_wmask[CRMD_PLV_MSB:CRMD_PLV_LSB])
                      | (i_csr_wvalue[CRMD_PLV_MSB:CRMD_PLV_LSB] & i_csr_wmask[CRMD_PLV_MSB:CRMD_PLV_LSB]);
    assign w_ie_new   = (r_crmd_ie & ~i_csr_wmask[CRMD_IE]) | (i_csr_wvalue[CRMD_IE] & i_csr_wmask[CRMD_IE]);
    assign w_da_new   = (r_crmd_da & ~i_csr_wmask[CRMD_DA]) | (i_csr_wvalue[CRMD_DA] & i_csr_wmask[CRMD_DA]);
    assign w_pplv_new = (r_prmd_pplv & ~i_csr_wmask[PRMD_PPLV_MSB:PRMD_PPLV_LSB])
                      | (i_csr_wvalue[PRMD_PPLV_MSB:PRMD_PPLV_LSB] & i_csr_wmask[PRMD_PPLV_MSB:PRMD_PPLV_LSB]);
    assign w_pie_new  = (r_prmd_pie & ~i_csr_wmask[PRMD_PIE]) | (i_csr_wvalue[PRMD_PIE] & i_csr_wmask[PRMD_PIE]);
    assign w_is_new   = (r_estat_is & ~i_csr_wmask[ESTAT_IS_MSB:ESTAT_IS_LSB])
                      | (i_csr_wvalue[ESTAT_IS_MSB:ESTAT_IS_LSB] & i_csr_wmask[ESTAT_IS_MSB:ESTAT_IS_LSB]);
    assign w_va_new   = (r_eentry_va & ~i_csr_wmask[31:EENTRY_VA_LSB])
                      | (i_csr_wvalue[31:EENTRY_VA_LSB] & i_csr_wmask[31:EENTRY_VA_LSB]);

    // Commit updates take priority over a software write to the same field.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_crmd_plv <= 2'b0;
            r_crmd_ie  <= 1'b0;
            r_crmd_da  <= 1'b1;
        end else begin
            if (i_ex_commit) begin
                r_crmd_plv <= 2'b0;
                r_crmd_ie  <= 1'b0;
            end else if (i_ertn_commit) begin
                r_crmd_plv <= r_prmd_pplv;
                r_crmd_ie  <= r_prmd_pie;
            end else if (i_csr_we && w_sel_crmd) begin
                r_crmd_plv <= w_plv_new;
                r_crmd_ie  <= w_ie_new;
            end
            if (i_csr_we && w_sel_crmd) begin
                r_crmd_da <= w_da_new;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prmd_pplv <= 2'b0;
            r_prmd_pie  <= 1'b0;
        end else if (i_ex_commit) begin
            r_prmd_pplv <= r_crmd_plv;
            r_prmd_pie  <= r_crmd_ie;
        end else if (i_csr_we && w_sel_prmd) begin
            r_prmd_pplv <= w_pplv_new;
            r_prmd_pie  <= w_pie_new;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_estat_is    <= 2'b0;
            r_estat_ecode <= 6'b0;
            r_estat_esub  <= 9'b0;
        end else begin
            if (i_csr_we && w_sel_estat) begin
                r_estat_is <= w_is_new;
            end
            if (i_ex_commit) begin
                r_estat_ecode <= ECODE_SYS;
                r_estat_esub  <= 9'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_era <= 32'b0;
        end else if (i_ex_commit) begin
            r_era <= i_ex_pc;
        end else if (i_csr_we && w_sel_era) begin
            r_era <= csr_merge(r_era, i_csr_wmask, i_csr_wvalue);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_eentry_va <= 26'b0;
        end else if (i_csr_we && w_sel_eentry) begin
            r_eentry_va <= w_va_new;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_save
        logic [31:0] r_save;

        assign w_sel_save[gi] = (i_csr_num == CSR_NUM_W'(CSR_SAVE0 + 14'(gi)));

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_save <= 32'b0;
            end else if (i_csr_we && w_sel_save[gi]) begin
                r_save <= csr_merge(r_save, i_csr_wmask, i_csr_wvalue);
            end
        end

        assign w_save_rd[gi] = w_sel_save[gi] ? r_save : 32'b0;
    end

    always_comb begin
        o_csr_rdata = 32'b0;
        if (w_sel_crmd)   o_csr_rdata = w_crmd_rd;
        if (w_sel_prmd)   o_csr_rdata = w_prmd_rd;
        if (w_sel_estat)  o_csr_rdata = w_estat_rd;
        if (w_sel_era)    o_csr_rdata = r_era;
        if (w_sel_eentry) o_csr_rdata = w_eentry_rd;
        for (int k = 0; k < 4; k++) begin
            o_csr_rdata = o_csr_rdata | w_save_rd[k];
        end
    end

    assign o_era    = r_era;
    assign o_eentry = w_eentry_rd;

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module  : wb_stage
// Brief   : Writeback stage: bundle register, GPR write port, debug trace and
//           syscall / ertn commit with redirect PC.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage
    import csr_pkg::*;
#(
    parameter int CSR_NUM_W = 14
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    wb_allowin,
    input  logic                    mem_wb_valid,
    input  logic [MEM_WB_BUS_W-1:0] mem_wb_bus,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    output logic [WB_ID_BUS_W-1:0]  wb_id_bus,
    output logic                    wb_ex,
    output logic                    ertn_flush,
    output logic [31:0]             flush_pc,
    output logic [31:0]             debug_wb_pc,
    output logic [3:0]              debug_wb_rf_we,
    output logic [4:0]              debug_wb_rf_wnum,
    output logic [31:0]             debug_wb_rf_wdata
);

    logic        r_wb_valid;
    mem_wb_bus_t r_bus;

    logic        w_wb_ex;
    logic        w_ertn_flush;
    logic        w_rf_we;
    logic        w_csr_we;
    logic        w_wb_csr;
    logic [31:0] w_csr_rdata;
    logic [31:0] w_rf_wdata;
    logic [31:0] w_era;
    logic [31:0] w_eentry;
    logic        w_unused_bits;

    // WB always completes in one cycle, so it never stalls MEM.
    assign wb_allowin = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wb_valid <= 1'b0;
            r_bus      <= '0;
        end else begin
            r_wb_valid <= mem_wb_valid & ~w_wb_ex & ~w_ertn_flush;
            if (mem_wb_valid && wb_allowin) begin
                r_bus <= mem_wb_bus;
            end
        end
    end

    assign w_wb_ex      = r_wb_valid & r_bus.syscall_ex;
    assign w_ertn_flush = r_wb_valid & r_bus.ertn & ~r_bus.syscall_ex;
    assign w_csr_we     = r_wb_valid & r_bus.csr_we & ~w_wb_ex;
    assign w_rf_we      = r_wb_valid & r_bus.gr_we & ~w_wb_ex;
    assign w_wb_csr     = r_wb_valid & (r_bus.csr_re | r_bus.csr_we);
    assign w_rf_wdata   = r_bus.csr_re ? w_csr_rdata : r_bus.result;

    csr_file #(
        .CSR_NUM_W (CSR_NUM_W)
    ) u_csr_file (
        .clk           (clk),
        .resetn        (resetn),
        .i_csr_num     (r_bus.csr_num),
        .o_csr_rdata   (w_csr_rdata),
        .i_csr_we      (w_csr_we),
        .i_csr_wmask   (r_bus.csr_wmask),
        .i_csr_wvalue  (r_bus.csr_wvalue),
        .i_ex_commit   (w_wb_ex),
        .i_ex_pc       (r_bus.pc),
        .i_ertn_commit (w_ertn_flush),
        .o_era         (w_era),
        .o_eentry      (w_eentry)
    );

    assign rf_we      = w_rf_we;
    assign rf_waddr   = r_bus.dest;
    assign rf_wdata   = w_rf_wdata;
    assign wb_id_bus  = {w_rf_we, r_bus.dest, w_rf_wdata, w_wb_csr, r_bus.csr_num};
    assign wb_ex      = w_wb_ex;
    assign ertn_flush = w_ertn_flush;
    assign flush_pc   = w_wb_ex      ? w_eentry :
                        w_ertn_flush ? w_era    : 32'b0;

    assign debug_wb_pc       = r_bus.pc;
    assign debug_wb_rf_we    = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = r_bus.dest;
    assign debug_wb_rf_wdata = w_rf_wdata;

    assign w_unused_bits = ^{r_bus.rsvd, r_bus.inst};

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module  : tb_wb_stage
// Brief   : Directed bench for wb_stage with a word-level CSR/pipeline model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_stage;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         mem_wb_valid;
    logic [184:0] mem_wb_bus;
    logic         wb_allowin;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [52:0]  wb_id_bus;
    logic         wb_ex;
    logic         ertn_flush;
    logic [31:0]  flush_pc;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_we;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    always #5 clk = ~clk;

    wb_stage #(.CSR_NUM_W(14)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .wb_allowin        (wb_allowin),
        .mem_wb_valid      (mem_wb_valid),
        .mem_wb_bus        (mem_wb_bus),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .wb_id_bus         (wb_id_bus),
        .wb_ex             (wb_ex),
        .ertn_flush        (ertn_flush),
        .flush_pc          (flush_pc),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: CSRs as whole words ----------------
    bit           m_valid;
    logic [184:0] m_bus;
    logic [31:0]  m_csr [int];

    function automatic logic [31:0] wr_mask(input int a);
        case (a)
            0:              return 32'h0000_000F;
            1:              return 32'h0000_0007;
            5:              return 32'h0000_0003;
            6:              return 32'hFFFF_FFFF;
            12:             return 32'hFFFF_FFC0;
            48, 49, 50, 51: return 32'hFFFF_FFFF;
            default:        return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (m_csr.exists(a)) return m_csr[a];
        return 32'h0;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid = 1'b0;
            m_bus   = '0;
            m_csr.delete();
            m_csr[0] = 32'h8;
        end else begin : model_step
            logic        ex, er;
            int          a;
            logic [31:0] crmd0, prmd0, msk;
            ex    = m_valid & m_bus[0];
            er    = m_valid & m_bus[1] & ~m_bus[0];
            crmd0 = m_read(0);
            prmd0 = m_read(1);
            if (m_valid && m_bus[81] && !ex) begin
                a   = int'(m_bus[79:66]);
                msk = m_bus[65:34] & wr_mask(a);
                if (wr_mask(a) != 0) m_csr[a] = (m_read(a) & ~msk) | (m_bus[33:2] & msk);
            end
            if (ex) begin
                m_csr[1] = (m_read(1) & ~32'h7) | (crmd0 & 32'h7);
                m_csr[0] = m_read(0) & ~32'h7;
                m_csr[6] = m_bus[182:151];
                m_csr[5] = (m_read(5) & 32'h3) | (32'h0B << 16);
            end
            if (er) begin
                m_csr[0] = (m_read(0) & ~32'h7) | (prmd0 & 32'h7);
            end
            m_valid = mem_wb_valid & ~ex & ~er;
            if (mem_wb_valid) m_bus = mem_wb_bus;
        end
    end

    always @(negedge clk) begin : compare
        logic        ex, er, we, csrb;
        logic [31:0] wd, fpc;
        ex   = m_valid & m_bus[0];
        er   = m_valid & m_bus[1] & ~m_bus[0];
        we   = m_valid & m_bus[183] & ~ex;
        wd   = m_bus[80] ? m_read(int'(m_bus[79:66])) : m_bus[118:87];
        fpc  = ex ? m_read(12) : (er ? m_read(6) : 32'h0);
        csrb = m_valid & (m_bus[80] | m_bus[81]);
        check("cmp_allowin", wb_allowin, 1'b1);
        check("cmp_rf_we", rf_we, we);
        check("cmp_rf_waddr", rf_waddr, m_bus[86:82]);
        check("cmp_rf_wdata", rf_wdata, wd);
        check("cmp_id_bus", wb_id_bus, {we, m_bus[86:82], wd, csrb, m_bus[79:66]});
        check("cmp_wb_ex", wb_ex, ex);
        check("cmp_ertn", ertn_flush, er);
        check("cmp_flush_pc", flush_pc, fpc);
        check("cmp_dbg_pc", debug_wb_pc, m_bus[182:151]);
        check("cmp_dbg_we", debug_wb_rf_we, {4{we}});
        check("cmp_dbg_wnum", debug_wb_rf_wnum, m_bus[86:82]);
        check("cmp_dbg_wdata", debug_wb_rf_wdata, wd);
    end

    // ---------------- stimulus ----------------
    function automatic logic [184:0] bnd(input logic gr_we, input logic [31:0] pc,
                                         input logic [31:0] res, input logic [4:0] dest,
                                         input logic cwe, input logic cre, input logic [13:0] num,
                                         input logic [31:0] wm, input logic [31:0] wv,
                                         input logic ertn, input logic sys);
        return {1'b0, gr_we, pc, 32'h0000_0013, res, dest, cwe, cre, num, wm, wv, ertn, sys};
    endfunction

    function automatic logic [184:0] csrrd(input logic [13:0] num, input logic [4:0] dest);
        return bnd(1'b1, 32'h1C00_0040, 32'hDEAD_0000, dest, 1'b0, 1'b1, num, 32'h0, 32'h0, 1'b0, 1'b0);
    endfunction

    function automatic logic [184:0] csrwr(input logic [13:0] num, input logic [31:0] wm, input logic [31:0] wv);
        return bnd(1'b0, 32'h1C00_0044, 32'h0, 5'd0, 1'b1, 1'b0, num, wm, wv, 1'b0, 1'b0);
    endfunction

    task automatic send(input logic [184:0] b);
        mem_wb_valid = 1'b1;
        mem_wb_bus   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_wb_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [13:0] num, input logic [31:0] exp, input string name);
        send(csrrd(num, 5'd12));
        check(name, rf_wdata, exp);
    endtask

    initial begin
        mem_wb_valid = 1'b0;
        mem_wb_bus   = '0;
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_allowin", wb_allowin, 1'b1);
        check("reset_rf_we", rf_we, 1'b0);
        check("reset_flush_pc", flush_pc, 32'h0);
        check("reset_id_bus", wb_id_bus, 53'h0);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;

        send(bnd(1'b1, 32'h1C00_0000, 32'h1234, 5'd5, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        check("alu_rf_we", rf_we, 1'b1);
        check("alu_rf_waddr", rf_waddr, 5'd5);
        check("alu_rf_wdata", rf_wdata, 32'h1234);
        check("alu_dbg_we", debug_wb_rf_we, 4'hF);

        send(bnd(1'b1, 32'h1C00_0004, 32'h0, 5'd6, 1'b1, 1'b1, 14'h30, 32'h0000_00FF, 32'hFFFF_FFFF, 1'b0, 1'b0));
        check("xchg_old", rf_wdata, 32'h0);
        rd(14'h30, 32'h0000_00FF, "save0_rd");
        rd(14'h0, 32'h8, "crmd_reset_rd");

        send(csrwr(14'h0, 32'hF, 32'h7));
        send(csrwr(14'hC, 32'hFFFF_FFFF, 32'h1C00_803F));
        rd(14'hC, 32'h1C00_8000, "eentry_rd");

        send(bnd(1'b1, 32'h1C00_0100, 32'h55, 5'd8, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b1));
        check("sys_wb_ex", wb_ex, 1'b1);
        check("sys_flush_pc", flush_pc, 32'h1C00_8000);
        check("sys_rf_we", rf_we, 1'b0);
        send(csrrd(14'h6, 5'd9));
        check("sys_bubble_rf_we", rf_we, 1'b0);
        check("sys_bubble_ex", wb_ex, 1'b0);
        rd(14'h6, 32'h1C00_0100, "era_rd");
        rd(14'h1, 32'h7, "prmd_rd");
        rd(14'h0, 32'h0, "crmd_after_sys");
        rd(14'h5, 32'h000B_0000, "estat_rd");

        send(bnd(1'b0, 32'h1C00_8010, 32'h0, 5'd0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b1, 1'b0));
        check("ertn_flush", ertn_flush, 1'b1);
        check("ertn_flush_pc", flush_pc, 32'h1C00_0100);
        check("ertn_wb_ex", wb_ex, 1'b0);
        idle();
        rd(14'h0, 32'h7, "crmd_after_ertn");

        send(bnd(1'b1, 32'h1C00_0200, 32'h77, 5'd10, 1'b1, 1'b0, 14'h0, 32'hF, 32'hF, 1'b0, 1'b1));
        check("sys_csr_rf_we", rf_we, 1'b0);
        check("sys_csr_wb_ex", wb_ex, 1'b1);
        idle();
        rd(14'h0, 32'h0, "crmd_sys_over_write");
        rd(14'h6, 32'h1C00_0200, "era_rd2");

        send(bnd(1'b0, 32'h1C00_0300, 32'h0, 5'd0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b1, 1'b1));
        check("both_wb_ex", wb_ex, 1'b1);
        check("both_ertn", ertn_flush, 1'b0);
        check("both_flush_pc", flush_pc, 32'h1C00_8000);
        idle();

        send(csrwr(14'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        rd(14'h5, 32'h000B_0003, "estat_is_rd");
        send(csrwr(14'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        rd(14'h7, 32'h0, "undef_rd");
        send(csrwr(14'h33, 32'hF0F0_F0F0, 32'hAAAA_AAAA));
        rd(14'h33, 32'hA0A0_A0A0, "save3_rd");
        send(csrwr(14'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        rd(14'h1, 32'h7, "prmd_mask_rd");

        send(bnd(1'b1, 32'h1C00_0400, 32'hBEEF, 5'd3, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        check("pre_rst_rf_we", rf_we, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_dbg_pc", debug_wb_pc, 32'h0);
        check("rst_rf_wdata", rf_wdata, 32'h0);
        mem_wb_valid = 1'b0;
        @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;
        rd(14'h0, 32'h8, "crmd_after_rst");
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
